// File: rtl/tb_dp_ram_obi.sv
// Dual-port byte-addressed RAM with OBI-style handshake: port A wide read-only instruction
// port, port B 32-bit read/write data port, fixed read latency and optional periodic grant stalls.
module tb_dp_ram_obi #(
  parameter int ADDR_WIDTH        = 22,
  parameter int DEPTH_BYTES       = 65536,
  parameter int INSTR_RDATA_WIDTH = 128,
  parameter int READ_LATENCY      = 1,
  parameter int STALL_MODE        = 0,
  parameter int STALL_PERIOD      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_a,
  output logic                         gnt_a,
  input  logic [ADDR_WIDTH-1:0]        addr_a,
  output logic                         rvalid_a,
  output logic [INSTR_RDATA_WIDTH-1:0] rdata_a,
  output logic                         err_a,
  input  logic                         req_b,
  output logic                         gnt_b,
  input  logic [ADDR_WIDTH-1:0]        addr_b,
  input  logic                         we_b,
  input  logic [3:0]                   be_b,
  input  logic [31:0]                  wdata_b,
  output logic                         rvalid_b,
  output logic [31:0]                  rdata_b,
  output logic                         err_b
);

  localparam int IDX_W   = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int A_BYTES = INSTR_RDATA_WIDTH / 8;
  localparam int CNT_W   = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH_BYTES);

  if ((DEPTH_BYTES < 1) || ((DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0) ||
      (longint'(DEPTH_BYTES) > (longint'(1) << ADDR_WIDTH))) begin : g_bad_depth
    $error("DEPTH_BYTES must be a power of two no larger than 2**ADDR_WIDTH");
  end
  if ((INSTR_RDATA_WIDTH % 32) != 0) begin : g_bad_width
    $error("INSTR_RDATA_WIDTH must be a multiple of 32");
  end
  if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..4");
  end
  if ((STALL_MODE == 1) && (STALL_PERIOD < 2)) begin : g_bad_period
    $error("STALL_PERIOD must be at least 2 when STALL_MODE=1");
  end

  logic [7:0] mem [DEPTH_BYTES];

  logic [ADDR_WIDTH-1:0] addr_a_al, addr_b_al;
  logic [IDX_W-1:0]      base_a, base_b;
  logic                  oob_a, oob_b;
  logic                  acc_a, acc_b;
  logic [CNT_W-1:0]      cnt;

  assign addr_a_al = addr_a & ~ADDR_WIDTH'(3);
  assign addr_b_al = addr_b & ~ADDR_WIDTH'(3);
  assign base_a    = addr_a_al[IDX_W-1:0];
  assign base_b    = addr_b_al[IDX_W-1:0];
  assign oob_a     = {1'b0, addr_a_al} >= LIMIT;
  assign oob_b     = {1'b0, addr_b_al} >= LIMIT;

  // Grants depend only on reset and the free-running stall counter, never on req.
  if (STALL_MODE == 1) begin : g_stall
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(STALL_PERIOD - 1)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end else begin : g_no_stall
    assign cnt = '0;
  end

  assign gnt_a = !rst && ((STALL_MODE == 0) || (cnt != CNT_W'(STALL_PERIOD - 1)));
  assign gnt_b = !rst && ((STALL_MODE == 0) || (cnt != '0));
  assign acc_a = req_a && gnt_a;
  assign acc_b = req_b && gnt_b;

  // Read data is sampled combinationally at accept; index arithmetic in IDX_W bits wraps at the top.
  logic [INSTR_RDATA_WIDTH-1:0] rd_a;
  logic [31:0]                  rd_b;

  always_comb begin
    rd_a = '0;
    if (!oob_a) begin
      for (int i = 0; i < A_BYTES; i++) begin
        rd_a[8*i +: 8] = mem[base_a + IDX_W'(i)];
      end
    end
  end

  always_comb begin
    rd_b = '0;
    if (!oob_b && !we_b) begin
      for (int k = 0; k < 4; k++) begin
        rd_b[8*k +: 8] = mem[base_b + IDX_W'(k)];
      end
    end
  end

  // Writes land at the clock edge, so a same-cycle port A read still sees the old bytes.
  always_ff @(posedge clk) begin
    if (acc_b && we_b && !oob_b) begin
      for (int k = 0; k < 4; k++) begin
        if (be_b[k]) begin
          mem[base_b + IDX_W'(k)] <= wdata_b[8*k +: 8];
        end
      end
    end
  end

  logic [READ_LATENCY-1:0]      vld_a_p, vld_b_p, err_a_p, err_b_p;
  logic [INSTR_RDATA_WIDTH-1:0] dat_a_p [READ_LATENCY];
  logic [31:0]                  dat_b_p [READ_LATENCY];

  // Latency pipeline only delays already-captured responses; reset drops everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_a_p <= '0;
      vld_b_p <= '0;
      err_a_p <= '0;
      err_b_p <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_a_p[i] <= '0;
        dat_b_p[i] <= '0;
      end
    end else begin
      vld_a_p[0] <= acc_a;
      err_a_p[0] <= acc_a && oob_a;
      dat_a_p[0] <= acc_a ? rd_a : '0;
      vld_b_p[0] <= acc_b;
      err_b_p[0] <= acc_b && oob_b;
      dat_b_p[0] <= acc_b ? rd_b : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_a_p[i] <= vld_a_p[i-1];
        err_a_p[i] <= err_a_p[i-1];
        dat_a_p[i] <= dat_a_p[i-1];
        vld_b_p[i] <= vld_b_p[i-1];
        err_b_p[i] <= err_b_p[i-1];
        dat_b_p[i] <= dat_b_p[i-1];
      end
    end
  end

  assign rvalid_a = vld_a_p[READ_LATENCY-1];
  assign err_a    = err_a_p[READ_LATENCY-1];
  assign rdata_a  = dat_a_p[READ_LATENCY-1];
  assign rvalid_b = vld_b_p[READ_LATENCY-1];
  assign err_b    = err_b_p[READ_LATENCY-1];
  assign rdata_b  = dat_b_p[READ_LATENCY-1];

endmodule

// File: tb/tb_tb_dp_ram_obi.sv
// Scoreboard bench for tb_dp_ram_obi: two configurations (latency 1 no stalls, latency 3 with
// periodic stalls), byte-array reference model, expected responses queued at accept time.
module tb_tb_dp_ram_obi;
  localparam int AW     = 12;
  localparam int DEPTH  = 256;
  localparam int W      = 128;
  localparam int PERIOD = 4;

  typedef struct {
    logic         err;
    logic [W-1:0] data;
    int           cyc;
  } resp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam int SM  = g;

    logic          rst = 1'b1;
    logic          req_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [3:0]    be_b = '0;
    logic [31:0]   wdata_b = '0;
    logic          gnt_a, gnt_b, rvalid_a, rvalid_b, err_a, err_b;
    logic [W-1:0]  rdata_a;
    logic [31:0]   rdata_b;
    bit            done_f = 1'b0;

    tb_dp_ram_obi #(
      .ADDR_WIDTH(AW), .DEPTH_BYTES(DEPTH), .INSTR_RDATA_WIDTH(W),
      .READ_LATENCY(LAT), .STALL_MODE(SM), .STALL_PERIOD(PERIOD)
    ) dut (
      .clk(clk), .rst(rst),
      .req_a(req_a), .gnt_a(gnt_a), .addr_a(addr_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a), .err_a(err_a),
      .req_b(req_b), .gnt_b(gnt_b), .addr_b(addr_b), .we_b(we_b), .be_b(be_b), .wdata_b(wdata_b),
      .rvalid_b(rvalid_b), .rdata_b(rdata_b), .err_b(err_b)
    );

    logic [7:0] mem_m [DEPTH];
    resp_t      qa[$];
    resp_t      qb[$];
    int         cyc = 0;
    int         since_rst = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or posedge rst) begin
      if (rst) since_rst <= 0;
      else     since_rst <= since_rst + 1;
    end

    function automatic bit model_err(input logic [AW-1:0] addr);
      return (int'(addr) & ~3) >= DEPTH;
    endfunction

    function automatic logic [W-1:0] model_read(input logic [AW-1:0] addr, input int nbytes);
      int base = int'(addr) & ~3;
      logic [W-1:0] r = '0;
      if (base < DEPTH) begin
        for (int i = 0; i < nbytes; i++) r[8*i +: 8] = mem_m[(base + i) % DEPTH];
      end
      return r;
    endfunction

    task automatic applyStimulus(input bit ra, input logic [AW-1:0] aa, input bit rb,
                                 input logic [AW-1:0] ab, input bit we, input logic [3:0] be,
                                 input logic [31:0] wd, output bit acc_a, output bit acc_b);
      resp_t r;
      req_a = ra; addr_a = aa; req_b = rb; addr_b = ab; we_b = we; be_b = be; wdata_b = wd;
      @(negedge clk);
      acc_a = ra && gnt_a;
      acc_b = rb && gnt_b;
      if (acc_a) begin
        r.err = model_err(aa); r.data = model_read(aa, W / 8); r.cyc = cyc;
        qa.push_back(r);
      end
      if (acc_b) begin
        r.err = model_err(ab); r.cyc = cyc;
        r.data = (we || r.err) ? '0 : model_read(ab, 4);
        qb.push_back(r);
        if (we && !r.err) begin
          for (int k = 0; k < 4; k++)
            if (be[k]) mem_m[(int'(ab) & ~3) + k] = wd[8*k +: 8];
        end
      end
      @(posedge clk);
      #1;
      req_a = 1'b0;
      req_b = 1'b0;
    endtask

    task automatic b_op(input bit we, input logic [AW-1:0] addr, input logic [3:0] be, input logic [31:0] wd);
      bit xa, xb;
      int tries = 0;
      do begin
        applyStimulus(1'b0, '0, 1'b1, addr, we, be, wd, xa, xb);
        tries++;
      end while (!xb && tries < 8);
      checkOutput($sformatf("cfg%0d gnt_b within 8 cycles", g), W'(xb), W'(1));
    endtask

    task automatic a_read(input logic [AW-1:0] addr);
      bit xa, xb;
      int tries = 0;
      do begin
        applyStimulus(1'b1, addr, 1'b0, '0, 1'b0, 4'h0, 32'h0, xa, xb);
        tries++;
      end while (!xa && tries < 8);
      checkOutput($sformatf("cfg%0d gnt_a within 8 cycles", g), W'(xa), W'(1));
    endtask

    // Monitor: grants against the stall rule, responses against the scoreboard queues.
    resp_t r_a, r_b;
    bit    exp_ga, exp_gb;
    always @(negedge clk) begin
      if (rst) begin
        checkOutput($sformatf("cfg%0d outputs in reset", g),
                    W'({rvalid_a, rvalid_b, err_a, err_b, gnt_a, gnt_b}), '0);
        checkOutput($sformatf("cfg%0d rdata in reset", g), rdata_a | W'(rdata_b), '0);
      end else begin
        exp_ga = (SM == 0) || ((since_rst % PERIOD) != PERIOD - 1);
        exp_gb = (SM == 0) || ((since_rst % PERIOD) != 0);
        checkOutput($sformatf("cfg%0d grants", g), W'({gnt_a, gnt_b}), W'({exp_ga, exp_gb}));
        if (rvalid_a) begin
          if (qa.size() == 0) begin
            checkOutput($sformatf("cfg%0d unexpected rvalid_a", g), W'(1), W'(0));
          end else begin
            r_a = qa.pop_front();
            checkOutput($sformatf("cfg%0d rdata_a", g), rdata_a, r_a.data);
            checkOutput($sformatf("cfg%0d err_a", g), W'(err_a), W'(r_a.err));
            checkOutput($sformatf("cfg%0d latency_a", g), W'(cyc - r_a.cyc), W'(LAT));
          end
        end else begin
          checkOutput($sformatf("cfg%0d idle a", g), rdata_a | W'(err_a), '0);
        end
        if (rvalid_b) begin
          if (qb.size() == 0) begin
            checkOutput($sformatf("cfg%0d unexpected rvalid_b", g), W'(1), W'(0));
          end else begin
            r_b = qb.pop_front();
            checkOutput($sformatf("cfg%0d rdata_b", g), W'(rdata_b), r_b.data);
            checkOutput($sformatf("cfg%0d err_b", g), W'(err_b), W'(r_b.err));
            checkOutput($sformatf("cfg%0d latency_b", g), W'(cyc - r_b.cyc), W'(LAT));
          end
        end else begin
          checkOutput($sformatf("cfg%0d idle b", g), W'(rdata_b) | W'(err_b), '0);
        end
      end
    end

    initial begin
      bit xa, xb;
      int na, nb, tries;
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      for (int w = 0; w < DEPTH / 4; w++) b_op(1'b1, AW'(w * 4), 4'hF, $urandom);

      b_op(1'b1, 12'h010, 4'hF, 32'hDEADBEEF);
      b_op(1'b0, 12'h010, 4'h0, 32'h0);
      b_op(1'b1, 12'h020, 4'hF, 32'h11223344);
      b_op(1'b1, 12'h020, 4'b0101, 32'hAABBCCDD);
      b_op(1'b0, 12'h022, 4'h0, 32'h0);
      b_op(1'b1, 12'h020, 4'h0, 32'hFFFFFFFF);
      b_op(1'b0, 12'h020, 4'h0, 32'h0);
      b_op(1'b1, 12'h104, 4'hF, 32'h0BADF00D);
      b_op(1'b0, 12'h004, 4'h0, 32'h0);
      b_op(1'b0, 12'hFFC, 4'h0, 32'h0);

      a_read(12'h0F8);
      a_read(12'h0FB);
      a_read(12'h100);
      a_read(12'hFFF);
      a_read(12'h000);

      tries = 0;
      while (!(gnt_a && gnt_b) && tries < 8) begin
        @(posedge clk);
        #1;
        tries++;
      end
      applyStimulus(1'b1, 12'h040, 1'b1, 12'h040, 1'b1, 4'hF, 32'h55555555, xa, xb);
      checkOutput($sformatf("cfg%0d same-cycle accept", g), W'({xa, xb}), W'(2'b11));
      a_read(12'h040);

      na = 0; nb = 0;
      for (int i = 0; i < 8; i++) begin
        applyStimulus(1'b1, AW'($urandom_range(0, 255)), 1'b1, AW'($urandom_range(0, 255)),
                      1'b0, 4'h0, 32'h0, xa, xb);
        na += int'(xa);
        nb += int'(xb);
      end
      checkOutput($sformatf("cfg%0d held-req accepts a", g), W'(na), W'((SM == 1) ? 6 : 8));
      checkOutput($sformatf("cfg%0d held-req accepts b", g), W'(nb), W'((SM == 1) ? 6 : 8));

      for (int i = 0; i < 300; i++) begin
        applyStimulus(1'($urandom), AW'($urandom_range(0, 300)), 1'($urandom),
                      AW'($urandom_range(0, 280)), 1'($urandom), 4'($urandom), $urandom, xa, xb);
      end

      b_op(1'b0, 12'h010, 4'h0, 32'h0);
      b_op(1'b0, 12'h040, 4'h0, 32'h0);
      #1 rst = 1'b1;
      qa.delete();
      qb.delete();
      #1 checkOutput($sformatf("cfg%0d rvalid_b after async reset", g), W'(rvalid_b), '0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      b_op(1'b0, 12'h040, 4'h0, 32'h0);
      a_read(12'h010);
      for (int i = 0; i < 8; i++) b_op(1'b0, AW'($urandom_range(0, 255)), 4'h0, 32'h0);

      tries = 0;
      while ((qa.size() + qb.size()) != 0 && tries < 20) begin
        @(posedge clk);
        tries++;
      end
      checkOutput($sformatf("cfg%0d responses drained", g), W'(qa.size() + qb.size()), '0);
      done_f = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 50000; i++) begin
      if (g_cfg[0].done_f && g_cfg[1].done_f) break;
      @(posedge clk);
    end
    if (!(g_cfg[0].done_f && g_cfg[1].done_f)) checkOutput("run timeout", W'(0), W'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
